// File: rtl/por_reset_sequencer.sv
// rtl/por_reset_sequencer.sv - power-on reset sequencer driving core/peripheral resets
// Core reset releases HOLD_CYCLES after power-good, peripheral reset PERIPH_DELAY later.
module por_reset_sequencer #(
   parameter int HOLD_CYCLES  = 4,
   parameter int PERIPH_DELAY = 8,
   parameter int SW_PULSE     = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic power_up,
   input  logic sw_rst_req,
   output logic core_rst,
   output logic periph_rst,
   output logic ready,
   output logic sw_rst_ack
);

   localparam int MAX_AB  = (HOLD_CYCLES > PERIPH_DELAY) ? HOLD_CYCLES : PERIPH_DELAY;
   localparam int MAX_CNT = (MAX_AB > SW_PULSE) ? MAX_AB : SW_PULSE;
   localparam int CW      = $clog2(MAX_CNT) + 1;

   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] PERIPH_LAST = CW'(PERIPH_DELAY - 1);
   localparam logic [CW-1:0] SW_LAST     = CW'(SW_PULSE - 1);

   typedef enum logic [2:0] {
      S_OFF,
      S_HOLD,
      S_CORE_UP,
      S_RUN,
      S_SW_RST
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          core_rst_nxt;
   logic          periph_rst_nxt;
   logic          ready_nxt;
   logic          ack_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_OFF;
         cnt        <= '0;
         core_rst   <= 1'b1;
         periph_rst <= 1'b1;
         ready      <= 1'b0;
         sw_rst_ack <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         core_rst   <= core_rst_nxt;
         periph_rst <= periph_rst_nxt;
         ready      <= ready_nxt;
         sw_rst_ack <= ack_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt + 1'b1;
      ack_nxt        = 1'b0;
      core_rst_nxt   = 1'b1;
      periph_rst_nxt = 1'b1;
      ready_nxt      = 1'b0;

      // Power loss overrides everything, including an in-flight software reset.
      if (!power_up) begin
         state_nxt = S_OFF;
         cnt_nxt   = '0;
      end else begin
         case (state)
            S_OFF: begin
               state_nxt = S_HOLD;
               cnt_nxt   = '0;
            end
            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state_nxt = S_CORE_UP;
                  cnt_nxt   = '0;
               end
            end
            S_CORE_UP: begin
               if (cnt == PERIPH_LAST) begin
                  state_nxt = S_RUN;
                  cnt_nxt   = '0;
               end
            end
            S_RUN: begin
               cnt_nxt = '0;
               if (sw_rst_req) begin
                  state_nxt = S_SW_RST;
               end
            end
            S_SW_RST: begin
               if (cnt == SW_LAST) begin
                  state_nxt = S_RUN;
                  cnt_nxt   = '0;
                  ack_nxt   = 1'b1;
               end
            end
            default: begin
               state_nxt = S_OFF;
               cnt_nxt   = '0;
            end
         endcase
      end

      // Registered outputs are decoded from the state being entered.
      core_rst_nxt   = (state_nxt == S_OFF) || (state_nxt == S_HOLD);
      periph_rst_nxt = (state_nxt != S_RUN);
      ready_nxt      = (state_nxt == S_RUN);
   end

endmodule

// File: tb/tb_por_reset_sequencer.sv
// tb/tb_por_reset_sequencer.sv - directed bench for por_reset_sequencer (HOLD 4 and HOLD 1)
module tb_por_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       power_up;
   logic       sw_rst_req;
   logic [1:0] core_rst;
   logic [1:0] periph_rst;
   logic [1:0] ready;
   logic [1:0] sw_rst_ack;

   int   total = 0;
   int   bad = 0;
   int   asrt_fail [2] = '{0, 0};
   int   age [2] = '{0, 0};
   int   inv_fail = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   por_reset_sequencer u_dut (
      .clk        (clk),
      .reset      (reset),
      .power_up   (power_up),
      .sw_rst_req (sw_rst_req),
      .core_rst   (core_rst[0]),
      .periph_rst (periph_rst[0]),
      .ready      (ready[0]),
      .sw_rst_ack (sw_rst_ack[0])
   );

   por_reset_sequencer #(.HOLD_CYCLES(1)) u_dut_h1 (
      .clk        (clk),
      .reset      (reset),
      .power_up   (power_up),
      .sw_rst_req (sw_rst_req),
      .core_rst   (core_rst[1]),
      .periph_rst (periph_rst[1]),
      .ready      (ready[1]),
      .sw_rst_ack (sw_rst_ack[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, exp);
      end
   endtask

   // power_up |-> ##[1:5] !core_rst, tracked as the age of the oldest open attempt
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int a;
         a = age[d];
         if (!chk_en) begin
            a = 0;
         end else begin
            if (a > 0) begin
               if (!core_rst[d]) begin
                  a = 0;
               end else if (a == 5) begin
                  asrt_fail[d] <= asrt_fail[d] + 1;
                  a = 0;
               end else begin
                  a = a + 1;
               end
            end
            if (a == 0 && power_up) a = 1;
         end
         age[d] <= a;
      end
   end

   always @(negedge clk) begin
      if ((core_rst & ~periph_rst) != 2'b00) inv_fail <= inv_fail + 1;
   end

   function automatic logic [2:0] stim(input int id, input int e);
      logic r, p, s;
      r = (e == 1);
      p = (e >= 2);
      s = 1'b0;
      case (id)
         2: p = (e >= 2 && e <= 4) || (e >= 7);
         3: s = (e == 20) || (e == 25);
         4: begin
            p = (e >= 2) && (e < 22);
            s = (e == 8) || (e == 20);
         end
         5: r = (e == 1) || (e == 16);
         default: ;
      endcase
      return {r, p, s};
   endfunction

   // {core_rst, periph_rst} after test edge e; h is the hold length of DUT d
   function automatic logic [1:0] exp_rst(input int id, input int d, input int e);
      int   h;
      logic c, p;
      h = (d == 0) ? 4 : 1;
      c = (e < 2 + h);
      p = (e < 10 + h);
      case (id)
         2: begin
            c = c || (e >= 5 && e < 7 + h);
            p = p || (e >= 5 && e < 15 + h);
         end
         3: p = p || (e >= 20 && e <= 23) || (e >= 25 && e <= 28);
         4: begin
            c = c || (e >= 22);
            p = p || (e >= 20);
         end
         5: begin
            c = c || (e >= 16 && e < 17 + h);
            p = p || (e >= 16 && e < 25 + h);
         end
         default: ;
      endcase
      return {c, p};
   endfunction

   task automatic run_test(input int id, input int n);
      for (int e = 1; e <= n; e++) begin
         logic [2:0] s;
         s          = stim(id, e);
         reset      = s[2];
         power_up   = s[1];
         sw_rst_req = s[0];
         chk_en     = (id == 1) && (e >= 2);
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            logic [1:0] x;
            logic       ack;
            x   = exp_rst(id, d, e);
            ack = (id == 3) && (e == 24 || e == 29);
            check($sformatf("t%0d e%0d d%0d core_rst", id, e, d), core_rst[d], x[1]);
            check($sformatf("t%0d e%0d d%0d periph_rst", id, e, d), periph_rst[d], x[0]);
            check($sformatf("t%0d e%0d d%0d ready", id, e, d), ready[d], !x[0]);
            check($sformatf("t%0d e%0d d%0d sw_rst_ack", id, e, d), sw_rst_ack[d], ack);
         end
      end
      chk_en     = 1'b0;
      sw_rst_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset      = 1'b1;
      power_up   = 1'b0;
      sw_rst_req = 1'b0;

      run_test(1, 40);
      check("release_window_h4", asrt_fail[0], 0);
      check("release_window_h1", asrt_fail[1], 0);

      run_test(2, 16);
      run_test(3, 32);
      run_test(4, 30);
      run_test(5, 32);

      check("core_implies_periph", inv_fail, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/por_reset_sequencer.md
# por_reset_sequencer

Power-on reset sequencer that generates the system reset tree from a raw `power_up` indication. Core reset releases a fixed number of cycles after power is reported good. Peripheral reset releases after a further delay, and a software-requested peripheral reset is provided. It is the driving end of the power-up/reset protocol: it guarantees the check `power_up |-> ##[1:5] !core_rst` holds whenever `power_up` stays high.

## Interface
- `HOLD_CYCLES`, 4: cycles from first sampled `power_up`=1 to `core_rst` release; legal range 1..4 (keeps release inside the 5-cycle window).
- `PERIPH_DELAY`, 8: cycles from `core_rst` release to `periph_rst` release; legal range ≥1.
- `SW_PULSE`, 4: `periph_rst` width for a software reset; legal range ≥1.
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high block reset.
- `power_up`  in  1  power-good level, sampled on `clk`.
- `sw_rst_req`  in  1  software peripheral-reset request, single-cycle pulse.
- `core_rst`  out  1  core reset, active-high, registered.
- `periph_rst`  out  1  peripheral reset, active-high, registered.
- `ready`  out  1  high only in RUN.
- `sw_rst_ack`  out  1  one-cycle pulse when a software reset completes.

## Operation
- States: OFF, HOLD, CORE_UP, RUN, SW_RST. One internal counter, width `$clog2(max(HOLD_CYCLES,PERIPH_DELAY,SW_PULSE))+1`. The counter clears on every state entry.
- Priority per edge, highest first: `reset`=1, then `power_up`=0, then normal transitions.
- `reset`=1: next state OFF, counter 0, `core_rst`=1, `periph_rst`=1, `ready`=0, `sw_rst_ack`=0.
- `power_up`=0 in any state: same as `reset` (OFF, all resets asserted, any SW_RST abandoned without ack).
- OFF: `power_up`=1 → HOLD.
- HOLD: counts sampled cycles; after `HOLD_CYCLES` → CORE_UP with `core_rst`←0.
- CORE_UP: counts; after `PERIPH_DELAY` → RUN with `periph_rst`←0 and `ready`←1.
- RUN: `sw_rst_req`=1 → SW_RST with `periph_rst`←1 and `ready`←0. `core_rst` stays 0.
- SW_RST: counts; after `SW_PULSE` → RUN with `periph_rst`←0, `ready`←1 and `sw_rst_ack`←1 for one cycle.
- `sw_rst_req` outside RUN is dropped: no queueing, no ack.
- A `sw_rst_req` sampled in RUN on the edge after an ack starts a new SW_RST.
- `core_rst`=1 implies `periph_rst`=1 in every cycle.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Let edge k be the first edge sampling `power_up`=1 in OFF.
  - `core_rst` falls at edge k+`HOLD_CYCLES`. A sampling check first sees it low at edge k+`HOLD_CYCLES`+1 (≤ k+5).
  - `periph_rst` falls and `ready` rises at edge k+`HOLD_CYCLES`+`PERIPH_DELAY`.
- `power_up`=0 sampled at edge j: `core_rst` and `periph_rst` are 1 and `ready` is 0 after edge j. Re-rise restarts the full sequence from a new k.
- `sw_rst_req` sampled at edge s in RUN:
  - `periph_rst`=1 and `ready`=0 from edge s.
  - `periph_rst` released at edge s+`SW_PULSE`.
  - `sw_rst_ack` high for the cycle after edge s+`SW_PULSE` only.
- Simultaneous `sw_rst_req`=1 and `power_up`=0: power loss wins, no SW_RST.
- `reset` mid-sequence (HOLD, CORE_UP, SW_RST): OFF at that edge. Any partial count is discarded.

## Test plan
- Defaults. `reset` high through edge 1; `power_up`=1 from edge 2 onward → `core_rst` falls at edge 6; `periph_rst` falls and `ready` rises at edge 14; `sw_rst_ack` never pulses.
- Hold `power_up` high continuously for 40 cycles with concurrent assertion `power_up |-> ##[1:5] !core_rst` bound to the outputs → zero assertion failures. Repeat with `HOLD_CYCLES`=1 and 4.
- Power glitch: `power_up`=1 at edges 2–4, 0 at edge 5, 1 from edge 7 → `core_rst` stays 1 through edge 10 and falls at edge 11.
- Software reset: after RUN reached at edge 14, pulse `sw_rst_req` at edge 20 → `periph_rst`=1 and `ready`=0 after edges 20–23; both restored at edge 24; `sw_rst_ack`=1 for exactly one cycle after edge 24; `core_rst` stays 0 throughout.
- Ignored request:
  - `sw_rst_req` pulsed at edge 8 (CORE_UP) → no ack; `periph_rst` still falls at edge 14.
  - `power_up`=0 at edge 22 during SW_RST → OFF, both resets 1, no ack.
- `reset` asserted at edge 16 in RUN → after edge 16, `core_rst`=1, `periph_rst`=1, `ready`=0. Deasserting with `power_up` high at edge 17 → `core_rst` falls at edge 21.
